// File: rtl/hblur_pkg.sv
// Shared types and constants for the horizontal [1,2,1]/4 smoothing stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hblur_pkg;

  typedef enum logic {
    KERNEL_BLUR = 1'b0,
    KERNEL_PASS = 1'b1
  } kernel_t;

  typedef enum logic {
    ROW_START = 1'b0,
    ROW_MID   = 1'b1
  } row_state_t;

  localparam int OUT_FIFO_DEPTH = 2;
  localparam int SUM_GUARD_BITS = 2;

  // a + 2b + c never exceeds 4*max, so two guard bits are enough
  function automatic int sum_width(input int bits);
    return bits + SUM_GUARD_BITS;
  endfunction

endpackage

// File: rtl/hblur_out_fifo.sv
// Two-entry output FIFO with a dual-entry push port (push1 only alongside push0).
// Latency: a pushed entry is visible at o_head/o_count on the next clock edge.
// Backpressure: none internally; the writer must never push past depth.
module hblur_out_fifo
  import hblur_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push0,
  input  logic [BITS-1:0] i_dat0,
  input  logic            i_push1,
  input  logic [BITS-1:0] i_dat1,
  input  logic            i_pop,
  output logic [BITS-1:0] o_head,
  output logic [1:0]      o_count
);

  logic [BITS-1:0] r_mem [OUT_FIFO_DEPTH];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;
  logic [1:0]      w_n_push;

  assign w_n_push = {1'b0, i_push0} + {1'b0, i_push1};
  assign o_head   = r_mem[r_rd_ptr];
  assign o_count  = r_count;

  // Storage, pointers and occupancy; a double push fills both slots from the write pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push0) r_mem[r_wr_ptr]  <= i_dat0;
      if (i_push1) r_mem[~r_wr_ptr] <= i_dat1;
      r_wr_ptr <= r_wr_ptr ^ w_n_push[0];
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + w_n_push - {1'b0, i_pop};
    end
  end

endmodule

// File: rtl/hblur_filter.sv
// Horizontal [1,2,1]/4 row smoother with edge replication; kernel/enable latched per frame.
// Latency: col c out 1 cycle after col c+1 accepted; last col follows the second-last release.
// Backpressure: output_ready is registered-only (2-entry FIFO); HBLUR_ROUND_EN selects rounding.
module hblur_filter
  import hblur_pkg::*;
#(
  parameter int BITS         = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FAST_BPM     = 120
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] pix_in,
  input  logic            valid_in,
  output logic            output_ready,
  input  logic            module_ready,
  input  logic            filter_enable,
  input  logic [7:0]      BPM_estimate,
  output logic [BITS-1:0] pix_out,
  output logic            valid_out
);

  localparam int CW    = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int SUM_W = sum_width(BITS);
  localparam logic [CW-1:0] LAST_COL   = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(IMAGE_HEIGHT - 1);
  localparam logic [7:0]    FAST_BPM_L = 8'(FAST_BPM);

  row_state_t      r_state, w_next_state;
  kernel_t         r_kernel;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [BITS-1:0] r_prev, r_cur;

  logic            w_accept, w_pop, w_last_col;
  logic            w_push0, w_push1;
  logic [BITS-1:0] w_dat0, w_dat1;
  logic [1:0]      w_count;

  // One kernel tap: b in pass-through, otherwise (a + 2b + c) / 4
  function automatic logic [BITS-1:0] f_tap(input logic [BITS-1:0] a,
                                            input logic [BITS-1:0] b,
                                            input logic [BITS-1:0] c,
                                            input kernel_t k);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
`ifdef HBLUR_ROUND_EN
    s = s + SUM_W'(2);
`else
    s = s + SUM_W'(0);
`endif
    if (k == KERNEL_PASS) return b;
    return BITS'(s >> 2);
  endfunction

  assign w_last_col   = (r_col == LAST_COL);
  assign w_accept     = valid_in && output_ready;
  assign valid_out    = (w_count != 2'd0);
  assign w_pop        = valid_out && module_ready;
  // Last column needs two free slots for its double push
  assign output_ready = (w_count == 2'd0) ||
                        ((w_count == 2'd1) && !((r_state == ROW_MID) && w_last_col));

  // Column/row position of the next pixel to be accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Kernel selection sampled only on the first pixel of a frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kernel <= KERNEL_BLUR;
    end else if (w_accept && (r_col == '0) && (r_row == '0)) begin
      r_kernel <= (!filter_enable || (BPM_estimate >= FAST_BPM_L)) ? KERNEL_PASS : KERNEL_BLUR;
    end
  end

  // Row FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ROW_START;
    else        r_state <= w_next_state;
  end

  // Sliding window; the first pixel of a row fills both taps (left edge replicate)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= '0;
      r_cur  <= '0;
    end else if (w_accept) begin
      r_prev <= (r_state == ROW_START) ? pix_in : r_cur;
      r_cur  <= pix_in;
    end
  end

  // Next state and FIFO pushes; the last column also emits the right-edge replicate
  always_comb begin
    w_next_state = r_state;
    w_push0      = 1'b0;
    w_push1      = 1'b0;
    w_dat0       = f_tap(r_prev, r_cur, pix_in, r_kernel);
    w_dat1       = f_tap(r_cur, pix_in, pix_in, r_kernel);
    case (r_state)
      ROW_START: begin
        if (w_accept) w_next_state = ROW_MID;
      end
      ROW_MID: begin
        if (w_accept) begin
          w_push0 = 1'b1;
          if (w_last_col) begin
            w_push1      = 1'b1;
            w_next_state = ROW_START;
          end
        end
      end
      default: w_next_state = ROW_START;
    endcase
  end

  hblur_out_fifo #(.BITS(BITS)) u_out_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push0 (w_push0),
    .i_dat0  (w_dat0),
    .i_push1 (w_push1),
    .i_dat1  (w_dat1),
    .i_pop   (w_pop),
    .o_head  (pix_out),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_hblur_filter.sv
// Directed + randomized bench for hblur_filter with a row-level reference model.
module tb_hblur_filter;

  localparam int W = 16;
  localparam int H = 3;
`ifdef HBLUR_ROUND_EN
  localparam int IMP_SIDE  = 2;
  localparam int EDGE_M2   = 13;
`else
  localparam int IMP_SIDE  = 1;
  localparam int EDGE_M2   = 12;
`endif
  localparam int EDGE_M1 = 25;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pix_in;
  logic       valid_in;
  logic       output_ready;
  logic       module_ready;
  logic       filter_enable;
  logic [7:0] BPM_estimate;
  logic [7:0] pix_out;
  logic       valid_out;

  typedef struct {
    int val;
    int tag;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   mr_pct = 100;
  int   m_cnt  = 0;
  int   m_col  = 0;
  int   m_row  = 0;
  bit   m_pass = 1'b0;
  exp_t exp_q[$];
  int   rowbuf[W];
  int   cap[2*W];

  hblur_filter #(.BITS(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FAST_BPM(120)) dut (
    .clk           (clk),
    .reset         (reset),
    .pix_in        (pix_in),
    .valid_in      (valid_in),
    .output_ready  (output_ready),
    .module_ready  (module_ready),
    .filter_enable (filter_enable),
    .BPM_estimate  (BPM_estimate),
    .pix_out       (pix_out),
    .valid_out     (valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_px(input int a, input int b, input int c, input bit pass);
    if (pass) return b;
`ifdef HBLUR_ROUND_EN
    return (a + 2*b + c + 2) / 4;
`else
    return (a + 2*b + c) / 4;
`endif
  endfunction

  // One clock: check outputs against the occupancy model, score releases, then advance.
  task automatic tick(output bit acc);
    exp_t e;
    module_ready = ($urandom_range(0, 99) < mr_pct);
    chk("valid_out", valid_out, m_cnt != 0);
    chk("output_ready", output_ready, (m_cnt == 0) || (m_cnt == 1 && m_col != W-1));
    if (valid_out && module_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL spurious_release: observed=%0d expected=no output", pix_out);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pix_out", pix_out, e.val);
        if (e.tag >= 0) cap[e.tag] = int'(pix_out);
      end
      if (m_cnt > 0) m_cnt--;
    end
    acc = valid_in && output_ready;
    if (acc) begin
      m_cnt += (m_col == 0) ? 0 : ((m_col == W-1) ? 2 : 1);
      if (m_col == W-1) begin
        m_col = 0;
        m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix();
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 64) begin
      tick(acc);
      n++;
    end
    chk("accept_timeout", acc, 1);
  endtask

  // Send n_pix pixels of rowbuf; expectations for the whole row are queued up front.
  task automatic send_row(input bit fe, input int bpm, input int n_pix,
                          input int tag_base, input bit bp);
    bit acc;
    if (m_col == 0 && m_row == 0) m_pass = (!fe || bpm >= 120);
    for (int c = 0; c < W; c++) begin
      exp_t e;
      e.val = ref_px(rowbuf[(c == 0) ? 0 : c-1], rowbuf[c], rowbuf[(c == W-1) ? W-1 : c+1], m_pass);
      e.tag = (tag_base < 0) ? -1 : tag_base + c;
      exp_q.push_back(e);
    end
    if (bp) mr_pct = 0;
    filter_enable = fe;
    BPM_estimate  = 8'(bpm);
    for (int c = 0; c < n_pix; c++) begin
      pix_in   = 8'(rowbuf[c]);
      valid_in = 1'b1;
      send_pix();
      if (c == 0) begin
        filter_enable = 1'($urandom);
        BPM_estimate  = 8'($urandom);
      end
      if (bp && c == 2) begin
        pix_in = 8'(rowbuf[3]);
        repeat (3) begin
          chk("bp_ready_low", output_ready, 0);
          tick(acc);
          chk("bp_no_accept", acc, 0);
        end
        mr_pct = 100;
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    valid_in = 1'b0;
    mr_pct   = 100;
    while (exp_q.size() > 0 && n < 200) begin
      tick(acc);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < W; i++) rowbuf[i] = $urandom_range(0, 255);
  endtask

  initial begin
    reset = 1'b0; pix_in = '0; valid_in = 1'b0; module_ready = 1'b0;
    filter_enable = 1'b0; BPM_estimate = '0;
    for (int i = 0; i < 2*W; i++) cap[i] = -1;
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_output_ready", output_ready, 1);
    chk("rst_pix_out", pix_out, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Flat frame under blur
    for (int r = 0; r < H; r++) begin
      for (int i = 0; i < W; i++) rowbuf[i] = 100;
      send_row(1'b1, 60, W, -1, 1'b0);
    end
    drain();

    // Impulse row, right-edge row, random row
    for (int i = 0; i < W; i++) rowbuf[i] = 0;
    rowbuf[5] = 6;
    send_row(1'b1, 60, W, 0, 1'b0);
    fill_random();
    rowbuf[W-3] = 0; rowbuf[W-2] = 10; rowbuf[W-1] = 30;
    send_row(1'b1, 60, W, W, 1'b0);
    fill_random();
    send_row(1'b1, 60, W, -1, 1'b0);
    drain();
    chk("impulse_col3", cap[3], 0);
    chk("impulse_col4", cap[4], IMP_SIDE);
    chk("impulse_col5", cap[5], 3);
    chk("impulse_col6", cap[6], IMP_SIDE);
    chk("impulse_col7", cap[7], 0);
    chk("edge_col_w2", cap[2*W-2], EDGE_M2);
    chk("edge_col_w1", cap[2*W-1], EDGE_M1);

    // Fast tempo at frame start: pass-through despite slow tempo later in the frame
    mr_pct = 70;
    fill_random(); send_row(1'b1, 150, W, -1, 1'b0);
    fill_random(); send_row(1'b1, 60, W, -1, 1'b0);
    fill_random(); send_row(1'b1, 60, W, -1, 1'b0);
    // Next frame relatches blur; disabling mid-frame has no effect
    mr_pct = 50;
    fill_random(); send_row(1'b1, 60, W, -1, 1'b0);
    fill_random(); send_row(1'b0, 60, W, -1, 1'b0);
    fill_random(); send_row(1'b0, 200, W, -1, 1'b0);
    drain();

    // Backpressure at frame start, then a normal frame tail
    fill_random(); send_row(1'b1, 60, W, -1, 1'b1);
    mr_pct = 100;
    fill_random(); send_row(1'b1, 60, W, -1, 1'b0);
    fill_random(); send_row(1'b0, 60, W, -1, 1'b0);
    drain();

    // Reset mid-row discards everything; next pixel is a new frame start
    mr_pct = 80;
    fill_random(); send_row(1'b1, 60, W/2, -1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_output_ready", output_ready, 1);
    chk("midrst_pix_out", pix_out, 0);
    exp_q.delete();
    m_cnt = 0; m_col = 0; m_row = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    mr_pct = 100;
    for (int r = 0; r < H; r++) begin
      fill_random();
      send_row(1'b1, 150, W, -1, 1'b0);
    end
    drain();
    chk("final_valid_out", valid_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
